race_controller: RTL
====================

Name: race_controller

Overview:
Top-level race sequencer that drives the shared 3-bit `state` bus consumed by both player physics engines (engines move only when state == 4).
- Runs the race flow: idle, car reset, countdown, race, pause, finish.
- Generates the game tick, counts laps per player from car positions, times the race and declares the winner.
- Sits between the input/button logic and the two physics engine instances; its outputs also feed the HUD renderer.

Parameters:
TICK_DIV, 1_666_666, clk cycles per game tick (60 Hz at 100 MHz).
TICKS_PER_SEC, 60, game ticks per countdown step.
LAPS, 3, laps needed to win (1..15).
CP_X, 10'd240, checkpoint: pos_x >= CP_X arms the player's lap flag.
FIN_X, 10'd40, finish zone: pos_x < FIN_X.
FIN_Y0, 10'd100, finish zone lower y bound (inclusive).
FIN_Y1, 10'd140, finish zone upper y bound (inclusive).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin race / restart after finish
pause  in  1  one-cycle pulse: toggle pause during race
p1_x  in  10  player 1 car x (pixel)
p1_y  in  10  player 1 car y
p2_x  in  10  player 2 car x
p2_y  in  10  player 2 car y
state  out  3  game state bus: 0 IDLE, 1 INIT, 2 COUNTDOWN, 3 PAUSE, 4 RACE, 5 FINISH
car_rst  out  1  high for exactly the one cycle state == INIT; ORed into the engines' rst
game_tick  out  1  one-cycle tick pulse
countdown  out  2  countdown digit 3/2/1, 0 otherwise
p1_lap  out  4  completed laps, player 1
p2_lap  out  4  completed laps, player 2
winner  out  2  0 none, 1 P1, 2 P2, 3 tie
race_ticks  out  16  game ticks spent in RACE, saturating at 16'hFFFF

Behaviour:
- Reset values: state = 0, car_rst = 0, game_tick = 0, countdown = 0, laps = 0, winner = 0, race_ticks = 0; tick counter = 0; lap flags cleared.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1, running in every state.
  - game_tick = 1 on the cycle the counter equals TICK_DIV-1.
- IDLE: start -> INIT on the next clk; all other inputs ignored.
- INIT (one clk cycle):
  - car_rst = 1; clear laps, lap flags, winner, race_ticks and sec_cnt.
  - countdown <= 3; next state COUNTDOWN (no tick needed).
- COUNTDOWN:
  - On each game_tick, sec_cnt increments.
  - At sec_cnt == TICKS_PER_SEC-1: sec_cnt <= 0, countdown decrements.
  - When countdown is 1 and wraps: countdown <= 0, state <= RACE.
  - Total duration is 3*TICKS_PER_SEC ticks. start and pause are ignored.
- RACE:
  - On each game_tick, race_ticks increments (saturating).
  - Per player, evaluated on game_tick with the positions present that cycle:
    - If pos_x >= CP_X, set flag.
    - Else if flag is set and pos_x < FIN_X and FIN_Y0 <= pos_y <= FIN_Y1: lap += 1, flag cleared.
  - Lap counters never exceed LAPS.
  - When any lap update reaches LAPS:
    - winner = 1 if only P1 reached it, 2 if only P2, 3 if both reached it on the same tick.
    - state <= FINISH on that same edge.
- Pause:
  - pause pulse in RACE -> PAUSE.
  - pause pulse in PAUSE -> RACE.
  - In PAUSE, race_ticks, flags and laps are frozen. The tick counter keeps running.
- Precedence: if a pause pulse and a race-ending lap arrive on the same cycle, FINISH wins.
- FINISH:
  - Outputs hold their values.
  - start -> INIT: full restart, with laps/winner cleared in INIT.
  - pause is ignored.
- start pulses are ignored in every state other than IDLE and FINISH.
- rst in any state returns to IDLE with reset values on the next edge, including mid-countdown and mid-race.
- All outputs are registered except car_rst, which is decoded from state == INIT (registered state only).

Test Plan:
- Test parameters: TICK_DIV = 4, TICKS_PER_SEC = 2, LAPS = 2.
- Start from IDLE: pulse start -> state 1 for exactly 1 clk with car_rst = 1, then state 2 with countdown = 3. countdown reads 2 after 2 ticks and 1 after 4 ticks; state = 4 with countdown = 0 after 6 ticks.
- P1 lap: in RACE, drive p1_x = 250 for 1 tick, then p1_x = 20, p1_y = 120 -> p1_lap = 1. Holding p1_x = 20 for further ticks gives no extra lap. Finish-zone entry with the flag clear -> no lap.
- Win and tie:
  - P1 completes 2 laps -> winner = 1, state = 5, race_ticks frozen.
  - Separate run: both players cross their 2nd finish on the same tick -> winner = 3.
- Pause: pause pulse in RACE -> state 3; positions toggling across the checkpoint/finish for 10 ticks leave laps and race_ticks unchanged. A second pause -> state 4. A pause during COUNTDOWN is ignored.
- Reset and restart:
  - rst asserted mid-COUNTDOWN (countdown = 2) -> next edge: state = 0, countdown = 0, all outputs zero.
  - start in FINISH -> INIT, laps = 0, winner = 0.

Source files
------------

// File: rtl/race_controller_if.sv
// Signal bundle between the race sequencer, the input/button logic, the two
// physics engines and the HUD renderer.
interface race_controller_if;
  logic        start;
  logic        pause;
  logic [9:0]  p1_x;
  logic [9:0]  p1_y;
  logic [9:0]  p2_x;
  logic [9:0]  p2_y;
  logic [2:0]  state;
  logic        car_rst;
  logic        game_tick;
  logic [1:0]  countdown;
  logic [3:0]  p1_lap;
  logic [3:0]  p2_lap;
  logic [1:0]  winner;
  logic [15:0] race_ticks;

  modport master (
    output start, pause, p1_x, p1_y, p2_x, p2_y,
    input  state, car_rst, game_tick, countdown, p1_lap, p2_lap, winner, race_ticks
  );

  modport slave (
    input  start, pause, p1_x, p1_y, p2_x, p2_y,
    output state, car_rst, game_tick, countdown, p1_lap, p2_lap, winner, race_ticks
  );
endinterface

// File: rtl/race_controller.sv
// Race sequencer: game tick, countdown, per-player lap counting, race timer,
// winner decision and the shared state bus that gates both physics engines.
module race_controller #(
  parameter int          TICK_DIV      = 1_666_666,
  parameter int          TICKS_PER_SEC = 60,
  parameter int          LAPS          = 3,
  parameter logic [9:0]  CP_X          = 10'd240,
  parameter logic [9:0]  FIN_X         = 10'd40,
  parameter logic [9:0]  FIN_Y0        = 10'd100,
  parameter logic [9:0]  FIN_Y1        = 10'd140
) (
  input logic             clk,
  input logic             rst,
  race_controller_if.slave bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SEC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SEC_ZERO  = SEC_W'(0);
  localparam logic [SEC_W-1:0] SEC_ONE   = SEC_W'(1);
  localparam logic [3:0]       LAPS_L    = 4'(LAPS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    COUNTDOWN = 3'd2,
    PAUSE     = 3'd3,
    RACE      = 3'd4,
    FINISH    = 3'd5
  } state_t;

  typedef struct packed {
    logic       flag;
    logic [3:0] lap;
    logic       hit;
  } lap_t;

  // A lap counts only after the checkpoint has armed the flag, so loitering in
  // the finish zone or reversing into it cannot score.
  function automatic lap_t lap_step(input logic flag, input logic [3:0] lap,
                                    input logic [9:0] x, input logic [9:0] y);
    lap_t r;
    r.flag = flag;
    r.lap  = lap;
    r.hit  = 1'b0;
    if (x >= CP_X) begin
      r.flag = 1'b1;
    end else if (flag && (x < FIN_X) && (y >= FIN_Y0) && (y <= FIN_Y1) && (lap < LAPS_L)) begin
      r.lap  = lap + 4'd1;
      r.flag = 1'b0;
      r.hit  = ((lap + 4'd1) == LAPS_L);
    end else begin
      r.flag = flag;
    end
    return r;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [CNT_W-1:0] tick_cnt_r, tick_nxt_s;
  logic            game_tick_r;
  logic [SEC_W-1:0] sec_r, sec_nxt_s;
  logic [1:0]      countdown_r, countdown_nxt_s;
  logic            p1_flag_r, p1_flag_nxt_s, p2_flag_r, p2_flag_nxt_s;
  logic [3:0]      p1_lap_r, p1_lap_nxt_s, p2_lap_r, p2_lap_nxt_s;
  logic [1:0]      winner_r, winner_nxt_s;
  logic [15:0]     race_ticks_r, race_ticks_nxt_s;
  lap_t            p1_step_s, p2_step_s;

  assign p1_step_s = lap_step(p1_flag_r, p1_lap_r, bus.p1_x, bus.p1_y);
  assign p2_step_s = lap_step(p2_flag_r, p2_lap_r, bus.p2_x, bus.p2_y);

  // Tick divider next value.
  always_comb begin
    if (tick_cnt_r == TICK_LAST) begin
      tick_nxt_s = CNT_ZERO;
    end else begin
      tick_nxt_s = tick_cnt_r + CNT_ONE;
    end
  end

  // Free-running divider; game_tick is registered in step with the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_r  <= CNT_ZERO;
      game_tick_r <= 1'b0;
    end else begin
      tick_cnt_r  <= tick_nxt_s;
      game_tick_r <= (tick_nxt_s == TICK_LAST);
    end
  end

  // Race flow next-state and datapath updates.
  always_comb begin
    state_nxt_s      = state_r;
    sec_nxt_s        = sec_r;
    countdown_nxt_s  = countdown_r;
    p1_flag_nxt_s    = p1_flag_r;
    p2_flag_nxt_s    = p2_flag_r;
    p1_lap_nxt_s     = p1_lap_r;
    p2_lap_nxt_s     = p2_lap_r;
    winner_nxt_s     = winner_r;
    race_ticks_nxt_s = race_ticks_r;
    case (state_r)
      IDLE, FINISH: begin
        // Results are wiped on the way into INIT so the HUD never shows stale laps there.
        if (bus.start) begin
          state_nxt_s      = INIT;
          sec_nxt_s        = SEC_ZERO;
          p1_flag_nxt_s    = 1'b0;
          p2_flag_nxt_s    = 1'b0;
          p1_lap_nxt_s     = 4'd0;
          p2_lap_nxt_s     = 4'd0;
          winner_nxt_s     = 2'd0;
          race_ticks_nxt_s = 16'd0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      INIT: begin
        countdown_nxt_s = 2'd3;
        state_nxt_s     = COUNTDOWN;
      end
      COUNTDOWN: begin
        if (game_tick_r) begin
          if (sec_r == SEC_LAST) begin
            sec_nxt_s = SEC_ZERO;
            if (countdown_r == 2'd1) begin
              countdown_nxt_s = 2'd0;
              state_nxt_s     = RACE;
            end else begin
              countdown_nxt_s = countdown_r - 2'd1;
            end
          end else begin
            sec_nxt_s = sec_r + SEC_ONE;
          end
        end else begin
          sec_nxt_s = sec_r;
        end
      end
      RACE: begin
        if (game_tick_r) begin
          if (race_ticks_r == 16'hFFFF) begin
            race_ticks_nxt_s = race_ticks_r;
          end else begin
            race_ticks_nxt_s = race_ticks_r + 16'd1;
          end
          p1_flag_nxt_s = p1_step_s.flag;
          p1_lap_nxt_s  = p1_step_s.lap;
          p2_flag_nxt_s = p2_step_s.flag;
          p2_lap_nxt_s  = p2_step_s.lap;
          // A finishing lap outranks a simultaneous pause request.
          if (p1_step_s.hit || p2_step_s.hit) begin
            winner_nxt_s = {p2_step_s.hit, p1_step_s.hit};
            state_nxt_s  = FINISH;
          end else if (bus.pause) begin
            state_nxt_s = PAUSE;
          end else begin
            state_nxt_s = RACE;
          end
        end else if (bus.pause) begin
          state_nxt_s = PAUSE;
        end else begin
          state_nxt_s = RACE;
        end
      end
      PAUSE: begin
        if (bus.pause) begin
          state_nxt_s = RACE;
        end else begin
          state_nxt_s = PAUSE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Race flow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      sec_r        <= SEC_ZERO;
      countdown_r  <= 2'd0;
      p1_flag_r    <= 1'b0;
      p2_flag_r    <= 1'b0;
      p1_lap_r     <= 4'd0;
      p2_lap_r     <= 4'd0;
      winner_r     <= 2'd0;
      race_ticks_r <= 16'd0;
    end else begin
      state_r      <= state_nxt_s;
      sec_r        <= sec_nxt_s;
      countdown_r  <= countdown_nxt_s;
      p1_flag_r    <= p1_flag_nxt_s;
      p2_flag_r    <= p2_flag_nxt_s;
      p1_lap_r     <= p1_lap_nxt_s;
      p2_lap_r     <= p2_lap_nxt_s;
      winner_r     <= winner_nxt_s;
      race_ticks_r <= race_ticks_nxt_s;
    end
  end

  assign bus.state      = state_r;
  assign bus.car_rst    = (state_r == INIT);
  assign bus.game_tick  = game_tick_r;
  assign bus.countdown  = countdown_r;
  assign bus.p1_lap     = p1_lap_r;
  assign bus.p2_lap     = p2_lap_r;
  assign bus.winner     = winner_r;
  assign bus.race_ticks = race_ticks_r;

endmodule
